// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction fetch stage. Holds the fetch PC, issues requests to an
// instruction memory, matches in-order responses to the PC that requested
// them, and presents fetched words to the IF/ID register through a 2-entry
// output queue.
//
// Handshakes: a transfer happens on any rising edge where the producer's
// valid and the consumer's ready are both high. Request side:
// imem_req_valid/imem_req_ready. Response side: imem_rsp_valid has no
// back-pressure, so the credit rule below ensures there is always room.
// Output side: if_valid with ~stall acting as the consumer's ready.
//
// Credit rule: a request may issue only while
// (outstanding requests + queued words) < 2, so every response in RUN
// always finds a free queue slot.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-low reset
//   stall               downstream not accepting; holds if_* outputs
//   redirect_valid/_pc  taken branch/jump: new PC, flush, drop in-flight
//   imem_req_*          fetch request (valid/ready/addr)
//   imem_rsp_*          in-order fetch response (valid/data)
//   if_valid/pc/instr   queue head toward IF/ID
//   fetch_count         dequeued instructions (perf counter)
//   bubble_count        cycles with nothing to offer and no stall
//   dbg_state_o         1 while in DRAIN
//
// Configuration macro: FETCH_PERF_CNT_EN enables the two performance
// counters; without it both counter outputs are tied to zero.
// ---------------------------------------------------------------------------
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instruction,
   output logic [31:0] fetch_count,
   output logic [31:0] bubble_count,
   output logic        dbg_state_o
);

   typedef enum logic {
      S_RUN   = 1'b0,
      S_DRAIN = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [1:0]  drop_q, drop_d;
   logic [1:0]  outst_q, outst_d;

   // Tag FIFO: PC of every accepted request, popped by each response.
   logic [31:0] tag_mem_q [2];
   logic        tag_wr_q, tag_wr_d;
   logic        tag_rd_q, tag_rd_d;

   // Output queue: fetched word plus its PC.
   logic [31:0] q_pc_q   [2];
   logic [31:0] q_data_q [2];
   logic        q_wr_q, q_wr_d;
   logic        q_rd_q, q_rd_d;
   logic [1:0]  q_cnt_q, q_cnt_d;

   logic        req_hs;
   logic        rsp_take;
   logic        rsp_keep;
   logic        deq;
   logic [2:0]  in_use;

   // A same-cycle dequeue does not free a credit; only registered counts.
   assign in_use         = {1'b0, outst_q} + {1'b0, q_cnt_q};
   assign imem_req_valid = reset && (state_q == S_RUN) && !redirect_valid
                           && (in_use < 3'd2);
   assign imem_req_addr  = {pc_q[31:2], 2'b00};
   assign req_hs         = imem_req_valid && imem_req_ready;

   // Responses are only meaningful while something is outstanding.
   assign rsp_take = imem_rsp_valid && (outst_q != 2'd0);
   // Responses are kept only in RUN without a redirect in the same cycle.
   assign rsp_keep = rsp_take && (state_q == S_RUN) && !redirect_valid;

   assign if_valid       = (q_cnt_q != 2'd0);
   assign if_pc          = if_valid ? q_pc_q[q_rd_q]   : 32'h0000_0000;
   assign if_instruction = if_valid ? q_data_q[q_rd_q] : NOP_INSTR;
   // The queue is flushed on redirect, so nothing is handed over that cycle.
   assign deq            = if_valid && !stall && !redirect_valid;

   assign dbg_state_o    = (state_q == S_DRAIN);

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      drop_d   = drop_q;
      outst_d  = outst_q + {1'b0, req_hs} - {1'b0, rsp_take};
      tag_wr_d = tag_wr_q ^ req_hs;
      tag_rd_d = tag_rd_q ^ rsp_take;
      q_wr_d   = q_wr_q ^ rsp_keep;
      q_rd_d   = q_rd_q ^ deq;
      q_cnt_d  = q_cnt_q + {1'b0, rsp_keep} - {1'b0, deq};

      // Redirect wins over stall: new PC and an empty output queue.
      if (redirect_valid) begin
         pc_d    = {redirect_pc[31:2], 2'b00};
         q_wr_d  = 1'b0;
         q_rd_d  = 1'b0;
         q_cnt_d = 2'd0;
      end

      case (state_q)
         S_RUN: begin
            if (redirect_valid) begin
               // A response arriving in the redirect cycle is already dropped.
               drop_d = outst_q - {1'b0, rsp_take};
               if (drop_d != 2'd0) begin
                  state_d = S_DRAIN;
               end
            end else if (req_hs) begin
               pc_d = pc_q + 32'd4;
            end
         end
         S_DRAIN: begin
            if (rsp_take) begin
               drop_d = drop_q - 2'd1;
            end
            if (drop_d == 2'd0) begin
               state_d = S_RUN;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_RUN;
         pc_q     <= RESET_PC;
         drop_q   <= 2'd0;
         outst_q  <= 2'd0;
         tag_wr_q <= 1'b0;
         tag_rd_q <= 1'b0;
         q_wr_q   <= 1'b0;
         q_rd_q   <= 1'b0;
         q_cnt_q  <= 2'd0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         drop_q   <= drop_d;
         outst_q  <= outst_d;
         tag_wr_q <= tag_wr_d;
         tag_rd_q <= tag_rd_d;
         q_wr_q   <= q_wr_d;
         q_rd_q   <= q_rd_d;
         q_cnt_q  <= q_cnt_d;
      end
   end

   // Storage arrays need no reset: the pointers and counts gate every read.
   always_ff @(posedge clk) begin
      if (req_hs) begin
         tag_mem_q[tag_wr_q] <= imem_req_addr;
      end
      if (rsp_keep) begin
         q_pc_q[q_wr_q]   <= tag_mem_q[tag_rd_q];
         q_data_q[q_wr_q] <= imem_rsp_data;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] bubble_cnt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_cnt_q  <= 32'd0;
         bubble_cnt_q <= 32'd0;
      end else begin
         if (deq) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if (!if_valid && !stall) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
         end
      end
   end

   assign fetch_count  = fetch_cnt_q;
   assign bubble_count = bubble_cnt_q;
`else
   assign fetch_count  = 32'd0;
   assign bubble_count = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Drives if_fetch_unit against an in-order memory with random latency and
// a reference model of the instruction stream: requests must walk the PC
// space in steps of 4 from reset or from the last redirect target, and the
// words presented downstream must be exactly the stream of requests made
// since the last redirect, in order, each carrying its own memory word.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] TB_NOP = 32'h0000_0013;

`ifdef FETCH_PERF_CNT_EN
   localparam bit PERF_EN = 1'b1;
`else
   localparam bit PERF_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instruction;
   logic [31:0] fetch_count;
   logic [31:0] bubble_count;
   logic        dbg_state_o;

   if_fetch_unit #(
      .RESET_PC  (RST_PC),
      .NOP_INSTR (TB_NOP)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instruction (if_instruction),
      .fetch_count    (fetch_count),
      .bubble_count   (bubble_count),
      .dbg_state_o    (dbg_state_o)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard state ----------------
   logic [31:0] exp_q[$];      // expected presentation order
   logic [31:0] mem_q[$];      // memory: addresses awaiting response
   int          due_q[$];      // memory: cycle each response is due
   logic [31:0] deq_hist[$];   // if_pc of each observed dequeue
   logic [31:0] exp_req_pc;
   bit          drop_flag;     // responses owed to a redirect remain
   bit          rst_drive;
   bit          last_hs, last_rsp;
   logic [31:0] last_hs_addr;
   int          cyc, mf, mb, n_deq;
   int          lat_lo, lat_hi;
   int          n_total, n_bad;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'h5EED_C0DE;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- driver: one clock cycle ----------------
   task automatic step(input bit redir, input logic [31:0] tgt, input bit st, input bit rdy);
      bit rsp_now;
      bit deq;
      int due;
      @(negedge clk);
      reset          = rst_drive;
      stall          = st;
      imem_req_ready = rdy;
      redirect_valid = redir;
      redirect_pc    = tgt;
      rsp_now        = (mem_q.size() > 0) && (due_q[0] <= cyc);
      imem_rsp_valid = rsp_now;
      imem_rsp_data  = rsp_now ? word_of(mem_q[0]) : $urandom();
      #1;
      last_hs  = 1'b0;
      last_rsp = rsp_now;
      if (!reset) begin
         chk("req_in_reset", 32'(imem_req_valid), 32'd0);
         mf = 0;
         mb = 0;
      end else begin
         if (drop_flag && mem_q.size() == 0) drop_flag = 1'b0;
         chk("drain_state", 32'(dbg_state_o), 32'(drop_flag));
         if (drop_flag) begin
            chk("drain_no_req", 32'(imem_req_valid), 32'd0);
            chk("drain_no_out", 32'(if_valid), 32'd0);
         end
         if (redir) chk("req_on_redirect", 32'(imem_req_valid), 32'd0);
         chk("fetch_count", fetch_count, PERF_EN ? 32'(mf) : 32'd0);
         chk("bubble_count", bubble_count, PERF_EN ? 32'(mb) : 32'd0);
         if (if_valid) begin
            if (exp_q.size() == 0) begin
               chk("if_valid_unexpected", 32'(if_valid), 32'd0);
            end else begin
               chk("if_pc", if_pc, exp_q[0]);
               chk("if_instr", if_instruction, word_of(exp_q[0]));
            end
         end else begin
            chk("idle_pc", if_pc, 32'd0);
            chk("idle_instr", if_instruction, TB_NOP);
         end
         deq = if_valid && !st && !redir;
         if (deq) begin
            deq_hist.push_back(if_pc);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            mf++;
            n_deq++;
         end
         if (!if_valid && !st) mb++;
         if (rsp_now) begin
            void'(mem_q.pop_front());
            void'(due_q.pop_front());
         end
         if (imem_req_valid && rdy) begin
            chk("req_addr", imem_req_addr, exp_req_pc);
            due = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (due_q.size() > 0 && due < due_q[$]) due = due_q[$];
            mem_q.push_back(imem_req_addr);
            due_q.push_back(due);
            exp_q.push_back(exp_req_pc);
            exp_req_pc   = exp_req_pc + 32'd4;
            last_hs      = 1'b1;
            last_hs_addr = imem_req_addr;
         end
         if (redir) begin
            exp_q.delete();
            exp_req_pc = {tgt[31:2], 2'b00};
            drop_flag  = (mem_q.size() > 0);
         end
         chk("outstanding_max2", 32'(mem_q.size() <= 2), 32'd1);
      end
      cyc++;
   endtask

   task automatic do_reset();
      mem_q.delete();
      due_q.delete();
      exp_q.delete();
      deq_hist.delete();
      drop_flag  = 1'b0;
      exp_req_pc = RST_PC;
      mf         = 0;
      mb         = 0;
      rst_drive  = 1'b0;
      step(1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_if_pc", if_pc, 32'd0);
      chk("rst_if_instr", if_instruction, TB_NOP);
      chk("rst_state", 32'(dbg_state_o), 32'd0);
      chk("rst_fetch_count", fetch_count, 32'd0);
      chk("rst_bubble_count", bubble_count, 32'd0);
      rst_drive = 1'b1;
   endtask

   task automatic wait_req(input string tag, input logic [31:0] exp);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         step(1'b0, 32'h0, 1'b0, 1'b1);
         seen = last_hs;
      end
      chk({tag, "_seen"}, 32'(seen), 32'd1);
      if (seen) chk(tag, last_hs_addr, exp);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit done;
      int dropped;
      n_total = 0;
      n_bad   = 0;
      cyc     = 0;
      n_deq   = 0;
      lat_lo  = 1;
      lat_hi  = 1;

      // Reset, then straight-line fetch with 1-cycle memory.
      do_reset();
      step(1'b0, 32'h0, 1'b0, 1'b1);
      chk("first_req_hs", 32'(last_hs), 32'd1);
      chk("first_req_addr", last_hs_addr, RST_PC);
      for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
      chk("seq_len", 32'(deq_hist.size() >= 3), 32'd1);
      for (int i = 0; i < 3 && i < deq_hist.size(); i++)
         chk("seq_pc", deq_hist[i], RST_PC + 32'(4 * i));

      // Stall long enough to fill the queue; requests must stop.
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 32'h0, 1'b1, 1'b1);
         if (i >= 3) begin
            chk("stall_no_req", 32'(imem_req_valid), 32'd0);
            chk("stall_if_valid", 32'(if_valid), 32'd1);
         end
      end
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

      // Redirect with two requests in flight.
      lat_lo = 3;
      lat_hi = 3;
      done   = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         if (mem_q.size() == 2 && due_q[0] > cyc) begin
            step(1'b1, 32'h0000_0100, 1'b0, 1'b1);
            done = 1'b1;
         end else begin
            step(1'b0, 32'h0, 1'b0, 1'b1);
         end
      end
      chk("redir2_found", 32'(done), 32'd1);
      dropped = 0;
      for (int i = 0; i < 20 && drop_flag; i++) begin
         step(1'b0, 32'h0, 1'b0, 1'b1);
         if (last_rsp && drop_flag) dropped++;
      end
      chk("drain_drops", 32'(dropped), 32'd2);
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         step(1'b0, 32'h0, 1'b0, 1'b1);
         done = if_valid;
      end
      chk("redir_valid_seen", 32'(done), 32'd1);
      chk("redir_first_pc", if_pc, 32'h0000_0100);

      // Unaligned redirect target and PC wrap.
      lat_lo = 1;
      lat_hi = 1;
      step(1'b1, 32'h0000_0203, 1'b0, 1'b1);
      wait_req("align_addr", 32'h0000_0200);
      step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
      wait_req("wrap_first", 32'hFFFF_FFFC);
      wait_req("wrap_next", 32'h0000_0000);

      // Counters: 10 dequeues from a fresh reset.
      do_reset();
      for (int k = 0; k < 200 && mf < 10; k++) step(1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b1);
      chk("fetch_count_10", fetch_count, PERF_EN ? 32'd10 : 32'd0);
      chk("bubble_total", bubble_count, PERF_EN ? 32'(mb) : 32'd0);

      // Random traffic with a reset in the middle.
      lat_lo = 1;
      lat_hi = 4;
      for (int i = 0; i < 800; i++) begin
         if (i == 400) do_reset();
         step($urandom_range(29, 0) == 0, $urandom(),
              $urandom_range(3, 0) == 0, $urandom_range(9, 0) < 7);
      end

      chk("progress", 32'(n_deq > 100), 32'd1);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
